// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache-side memory request arbiter and
// the schedulers that reuse its round-robin picker.
package cache_pkg;

  localparam int CACHE_NUM_REQ  = 2;
  localparam int CACHE_ID_WIDTH = $clog2(CACHE_NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef logic [CACHE_ID_WIDTH-1:0] req_id_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr,
// wrapping modulo NUM_REQ. rr_ptr is assumed to be below NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] winner_id
);

  logic [ID_WIDTH-1:0] cand [NUM_REQ];

  // cand[i] is the requester i positions after rr_ptr, already wrapped.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
    logic [ID_WIDTH:0] sum;
    assign sum     = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
    assign cand[i] = (sum >= (ID_WIDTH+1)'(NUM_REQ))
                     ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_REQ))
                     : sum[ID_WIDTH-1:0];
  end

  assign found = |req;

  // Scan from farthest to nearest so the nearest set candidate wins.
  always_comb begin
    winner_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) winner_id = cand[i];
    end
  end

endmodule

// File: rtl/cache_mem_arb.sv
// Transaction-locked round-robin arbiter sharing the downstream memory request
// queue between cache controllers, plus ID-based response routing.
module cache_mem_arb
  import cache_pkg::*;
#(
  parameter int NUM_REQ    = CACHE_NUM_REQ,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]            req_rdy_o,
  output logic                          dvld_o,
  input  logic                          drdy_i,
  output logic [DATA_WIDTH-1:0]         ddat_o,
  output logic                          dlast_o,
  output logic [ID_WIDTH-1:0]           did_o,
  input  logic                          rvld_i,
  input  logic [ID_WIDTH-1:0]           rid_i,
  input  logic [DATA_WIDTH-1:0]         rdat_i,
  output logic [NUM_REQ-1:0]            rsp_vld_o,
  output logic [DATA_WIDTH-1:0]         rsp_dat_o,
  output arb_state_e                    dbg_state,
  output logic [ID_WIDTH-1:0]           dbg_rr_ptr
);

  // Handshakes: a beat moves when valid and ready are both high on a rising
  // clk edge; valid, data and last stay stable until then, and ready may
  // depend combinationally on valid. Responses have no ready.

  arb_state_e          state, state_nxt;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] rr_ptr_nxt;
  logic [ID_WIDTH-1:0] winner_id;
  logic                found;
  logic                beat_done;
  logic                txn_end;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req       (req_vld_i),
    .rr_ptr    (rr_ptr),
    .found     (found),
    .winner_id (winner_id)
  );

  assign beat_done  = dvld_o & drdy_i;
  assign txn_end    = (state == BUSY) & beat_done & dlast_o;
  assign rr_ptr_nxt = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : grant_id + ID_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) grant_id <= winner_id;
      if (txn_end) rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (txn_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by state alone, so an async reset clears them at once.
  always_comb begin
    req_rdy_o = '0;
    dvld_o    = 1'b0;
    ddat_o    = '0;
    dlast_o   = 1'b0;
    did_o     = '0;
    if (state == BUSY) begin
      did_o = grant_id;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_id == ID_WIDTH'(k)) begin
          dvld_o       = req_vld_i[k];
          ddat_o       = req_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
          dlast_o      = req_last_i[k];
          req_rdy_o[k] = drdy_i;
        end
      end
    end
  end

  // Out-of-range IDs match no requester and the response is dropped.
  always_comb begin
    rsp_vld_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_vld_o[k] = rvld_i && (rid_i == ID_WIDTH'(k));
    end
  end

  assign rsp_dat_o  = rdat_i;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule
